mult_parity_responder: RTL and testbench

- Responder end of the multiplier operation protocol. It accepts an A/B operand pair with per-operand parity over a req/ack handshake, checks parity, and multiplies with a sequential shift-add engine.
- Returns the product with result parity, a one-cycle ready strobe and an argument-parity error flag.
- It is the DUT-side counterpart that the multiplier testbench stimulus (reset, correct input, incorrect A, incorrect B, incorrect A and B) drives.

---
 rtl/mult_parity_responder.sv | 105 ++++++++++
 tb/tb_mult_parity_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_parity_responder.sv
// Responder side of the multiplier protocol: parity-checked operand handshake,
// sequential shift-add multiply. Optional MULT_EARLY_TERM_EN ends MULT once B is exhausted.
module mult_parity_responder #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error
);
    localparam int RW    = 2 * DATA_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t              state_q;
    logic [RW-1:0]       a_q, acc_q, result_q;
    logic [DATA_W-1:0]   b_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ack_q, rdy_q, res_par_q, err_q;

    logic                arg_err;
    logic [RW-1:0]       a_d, acc_d;
    logic [DATA_W-1:0]   b_d;
    logic                last_d;

    always_comb begin
        arg_err = (arg_a_parity != ^arg_a) | (arg_b_parity != ^arg_b);
        acc_d   = acc_q + (b_q[0] ? a_q : '0);
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        last_d  = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef MULT_EARLY_TERM_EN
        // Remaining B bits are all zero, so further steps cannot change the sum.
        last_d  = last_d | (b_d == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            res_par_q <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        a_q   <= {{DATA_W{1'b0}}, arg_a};
                        b_q   <= arg_b;
                        acc_q <= '0;
                        cnt_q <= '0;
                        ack_q <= 1'b1;
                        if (arg_err) begin
                            result_q  <= '0;
                            res_par_q <= 1'b0;
                            err_q     <= 1'b1;
                            rdy_q     <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= MULT;
                        end
                    end
                end
                MULT: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        result_q  <= acc_d;
                        res_par_q <= ^acc_d;
                        rdy_q     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack              = ack_q;
    assign result           = result_q;
    assign result_parity    = res_par_q;
    assign result_rdy       = rdy_q;
    assign arg_parity_error = err_q;
endmodule

// File: tb/tb_mult_parity_responder.sv
// Scoreboard bench for mult_parity_responder: stimulus pushes expected results,
// a negedge monitor pops and checks them (value, parity, error flag, latency from ack).
module tb_mult_parity_responder;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst, req;
    logic [DW-1:0]   arg_a, arg_b;
    logic            arg_a_parity, arg_b_parity;
    logic            ack, result_rdy, result_parity, arg_parity_error;
    logic [2*DW-1:0] result;

    mult_parity_responder #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req),
        .arg_a(arg_a), .arg_a_parity(arg_a_parity),
        .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .ack(ack), .result(result), .result_parity(result_parity),
        .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] res;
        logic            par;
        logic            err;
        int              lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, ack_cyc = 0;
    int   n_cmp = 0, n_err = 0;

    always @(posedge clk) cyc++;

    // MULT length as seen between ack and result_rdy
    function automatic int lat_of(input logic [DW-1:0] b, input logic err);
        int n;
        if (err) return 0;
`ifdef MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < DW; i++) if (b[i]) n = i + 1;
`else
        n = DW;
`endif
        return n;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ack) ack_cyc = cyc;
        if (result_rdy) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rdy at cycle %0d result=%h", cyc, result);
            end else begin
                e = q.pop_front();
                if (result !== e.res || result_parity !== e.par ||
                    arg_parity_error !== e.err || (cyc - ack_cyc) != e.lat) begin
                    n_err++;
                    $display("FAIL result: got res=%h par=%b err=%b lat=%0d, want res=%h par=%b err=%b lat=%0d",
                             result, result_parity, arg_parity_error, cyc - ack_cyc,
                             e.res, e.par, e.err, e.lat);
                end
            end
        end
    end

    task automatic push(input logic [2*DW-1:0] r, input logic p, input logic err,
                        input logic [DW-1:0] b);
        exp_t e;
        e.res = r; e.par = p; e.err = err; e.lat = lat_of(b, err);
        q.push_back(e);
    endtask

    // Raise req with operands, wait (bounded) for ack, return the ack cycle.
    task automatic start(input logic [DW-1:0] a, input logic ap,
                         input logic [DW-1:0] b, input logic bp, output int k);
        int t = 0;
        arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
        k = -1;
        while (t < 40) begin
            @(negedge clk);
            if (ack) begin k = cyc; break; end
            t++;
        end
        if (k < 0) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout a=%h b=%h", a, b);
        end
    endtask

    task automatic op(input logic [DW-1:0] a, input logic ap,
                      input logic [DW-1:0] b, input logic bp,
                      input logic [2*DW-1:0] r, input logic p, input logic err);
        int k;
        push(r, p, err, b);
        start(a, ap, b, bp, k);
        req = 1'b0;
        repeat (lat_of(b, err) + 3) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (ack !== 1'b0 || result_rdy !== 1'b0 || arg_parity_error !== 1'b0 ||
            result !== '0 || result_parity !== 1'b0) begin
            n_err++;
            $display("FAIL %s: ack=%b rdy=%b err=%b res=%h par=%b, want all 0",
                     name, ack, result_rdy, arg_parity_error, result, result_parity);
        end
    endtask

    initial begin
        int k1, k2;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k1, k2;
        rst = 1'b1; req = 1'b1;
        arg_a = 16'd3; arg_a_parity = 1'b0; arg_b = 16'd5; arg_b_parity = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b0; req = 1'b0;
        @(negedge clk);

        op(16'd3, 1'b0, 16'd5, 1'b0, 32'd15, 1'b0, 1'b0);
        op(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0);
        op(16'd3, 1'b1, 16'd5, 1'b0, 32'd0, 1'b0, 1'b1);
        op(16'd3, 1'b0, 16'd5, 1'b0, 32'd15, 1'b0, 1'b0);
        op(16'd3, 1'b0, 16'd5, 1'b1, 32'd0, 1'b0, 1'b1);
        op(16'd3, 1'b1, 16'd5, 1'b1, 32'd0, 1'b0, 1'b1);
        op(16'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        op(16'h8000, 1'b1, 16'd2, 1'b1, 32'h00010000, 1'b1, 1'b0);

        // Abort mid-operation: nothing pushed, so any result_rdy is flagged.
        start(16'd9, 1'b0, 16'd9, 1'b0, k1);
        req = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_reset");
        repeat (DW + 4) @(negedge clk);
        check_idle("post_abort");
        op(16'd7, 1'b1, 16'd2, 1'b1, 32'd14, 1'b1, 1'b0);

        // Back-to-back with req held; operands swapped while busy.
        push(32'd6, 1'b0, 1'b0, 16'd3);
        push(32'd16, 1'b1, 1'b0, 16'd4);
        start(16'd2, 1'b1, 16'd3, 1'b0, k1);
        arg_a = 16'd4; arg_a_parity = 1'b1; arg_b = 16'd4; arg_b_parity = 1'b1;
        start(16'd4, 1'b1, 16'd4, 1'b1, k2);
        req = 1'b0;
        n_cmp++;
        if (k2 - k1 != lat_of(16'd3, 1'b0) + 2) begin
            n_err++;
            $display("FAIL b2b_ack_gap: got %0d, want %0d", k2 - k1, lat_of(16'd3, 1'b0) + 2);
        end
        repeat (DW + 4) @(negedge clk);

        op(16'h1234, 1'b1, 16'd1, 1'b1, 32'h00001234, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL missing_rdy: %0d expected results never seen, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
